// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // {enable, odd}
    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_EVEN = 2'b10;
    localparam logic [1:0] PARITY_ODD  = 2'b11;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Line synchroniser plus a two-deep tick-sample history; the vote combines the
// two previous tick samples with the current synced level.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_rx,
    output logic rx_s,
    output logic vote
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0]             samp_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync_q <= '1;
            samp_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
            if (i_tick)
                samp_q <= {samp_q[0], sync_q[SYNC_STAGES-1]};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign vote = maj3(samp_q[1], samp_q[0], rx_s);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: configurable frame format, run-time parity,
// majority-voted bit decisions, per-frame error flags and a valid/ready port.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int N_DATA      = 8,
    parameter int M_STOP      = 1,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_tick,
    input  logic              i_rx,
    input  logic              i_parity_en,
    input  logic              i_parity_odd,
    input  logic              i_ready,
    output logic [N_DATA-1:0] o_data,
    output logic              o_valid,
    output logic              o_parity_err,
    output logic              o_frame_err,
    output logic              o_break,
    output logic              o_overrun,
    output logic              o_busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(N_DATA);
    // Vote lands on the tick after mid-bit, once samples mid-1, mid, mid+1 are in.
    localparam logic [CNT_W-1:0] CNT_VOTE  = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(N_DATA - 1);
    localparam logic             STOP_LAST = 1'(M_STOP - 1);

    rx_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [BIT_W-1:0]  bit_idx;
    logic              stop_idx;
    logic [N_DATA-1:0] shreg;
    logic [1:0]        par_mode;
    logic              pbit;
    logic              first_stop;
    logic              ferr_acc;
    logic              rx_s;
    logic              vote;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_tick (i_tick),
        .i_rx   (i_rx),
        .rx_s   (rx_s),
        .vote   (vote)
    );

    // Frame completion and its flags, evaluated on the last stop-bit decision.
    logic done, fin_first, fin_ferr, fin_perr, fin_brk;
    assign done      = i_tick && (state == STOP) && (cnt == CNT_LAST) && (stop_idx == STOP_LAST);
    assign fin_first = (stop_idx == 1'b0) ? vote : first_stop;
    assign fin_ferr  = ferr_acc | ~vote;
    assign fin_perr  = par_mode[1] && ((^shreg ^ pbit) != par_mode[0]);
    assign fin_brk   = (shreg == '0) && (!par_mode[1] || !pbit) && !fin_first;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            par_mode   <= PARITY_NONE;
            pbit       <= 1'b0;
            first_stop <= 1'b1;
            ferr_acc   <= 1'b0;
        end else if (i_tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        cnt      <= '0;
                        par_mode <= i_parity_en ? (i_parity_odd ? PARITY_ODD : PARITY_EVEN)
                                                : PARITY_NONE;
                    end
                end
                START: begin
                    if (cnt == CNT_VOTE) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= vote ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shreg <= {vote, shreg[N_DATA-1:1]};
                        if (bit_idx == BIT_LAST) begin
                            stop_idx <= 1'b0;
                            ferr_acc <= 1'b0;
                            pbit     <= 1'b0;
                            state    <= par_mode[1] ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        pbit  <= vote;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt      <= '0;
                        ferr_acc <= ferr_acc | ~vote;
                        if (stop_idx == 1'b0)
                            first_stop <= vote;
                        if (stop_idx == STOP_LAST)
                            state <= vote ? IDLE : WAIT_HIGH;
                        else
                            stop_idx <= stop_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A completing frame is dropped only when the held word is still unaccepted.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
            o_overrun    <= 1'b0;
        end else if (done) begin
            if (!o_valid || i_ready) begin
                o_data       <= shreg;
                o_valid      <= 1'b1;
                o_parity_err <= fin_perr;
                o_frame_err  <= fin_ferr;
                o_break      <= fin_brk;
                o_overrun    <= 1'b0;
            end else begin
                o_overrun <= 1'b1;
            end
        end else if (o_valid && i_ready) begin
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: directed frame scenarios plus randomized frames checked
// against a frame-level model of the received word and its flags.
module tb_uart_rx_os;

    localparam int N_DATA = 8;
    localparam int M_STOP = 2;
    localparam int OS     = 16;
    localparam int SYNC   = 2;
    localparam int TPER   = 4;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b0;
    logic              i_tick = 1'b0;
    logic              i_rx = 1'b1;
    logic              i_parity_en = 1'b0;
    logic              i_parity_odd = 1'b0;
    logic              i_ready = 1'b1;
    logic [N_DATA-1:0] o_data;
    logic              o_valid, o_parity_err, o_frame_err, o_break, o_overrun, o_busy;

    int errors = 0;
    int checks = 0;
    int tcnt = 0;
    int vld_cycles = 0;
    logic [10:0] words[$];   // {break, frame_err, parity_err, data}

    uart_rx_os #(.N_DATA(N_DATA), .M_STOP(M_STOP), .OVERSAMPLE(OS), .SYNC_STAGES(SYNC)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_tick       (i_tick),
        .i_rx         (i_rx),
        .i_parity_en  (i_parity_en),
        .i_parity_odd (i_parity_odd),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_parity_err (o_parity_err),
        .o_frame_err  (o_frame_err),
        .o_break      (o_break),
        .o_overrun    (o_overrun),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        tcnt   = (tcnt + 1) % TPER;
        i_tick = (tcnt == 0);
    end

    always @(negedge i_clk) begin
        if (i_rst && o_valid) vld_cycles++;
        if (i_rst && o_valid && i_ready)
            words.push_back({o_break, o_frame_err, o_parity_err, o_data});
    end

    // Expected word from the frame's bit levels (two stop bits on the line).
    function automatic logic [10:0] ref_frame(input logic [7:0] d, input logic pen,
                                              input logic podd, input logic pb,
                                              input logic s0, input logic s1);
        logic perr, ferr, brk;
        perr = pen && ((^d ^ pb) != podd);
        ferr = !s0 || !s1;
        brk  = (d == 8'h00) && (!pen || !pb) && !s0;
        return {brk, ferr, perr, d};
    endfunction

    task automatic wait_tick();
        do @(posedge i_clk); while (i_tick !== 1'b1);
        #1;
    endtask

    task automatic drive_ticks(input logic lvl, input int n);
        i_rx = lvl;
        repeat (n) wait_tick();
    endtask

    // glitch_bit: frame bit index whose middle tick is inverted (-1: none).
    // scramble: flip the parity inputs once the frame is under way.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pb,
                              input logic s0, input logic s1, input int glitch_bit,
                              input int idle, input logic scramble);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < N_DATA; i++) bits.push_back(d[i]);
        if (pen) bits.push_back(pb);
        bits.push_back(s0);
        bits.push_back(s1);
        for (int k = 0; k < bits.size(); k++) begin
            if (scramble && k == 2) begin
                i_parity_en  = ~i_parity_en;
                i_parity_odd = ~i_parity_odd;
            end
            if (k == glitch_bit) begin
                drive_ticks(bits[k], 8);
                drive_ticks(~bits[k], 1);
                drive_ticks(bits[k], 7);
            end else begin
                drive_ticks(bits[k], OS);
            end
        end
        drive_ticks(1'b1, idle);
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        checks++;
        if ({o_valid, o_parity_err, o_frame_err, o_break, o_overrun, o_busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b expected 000000",
                     {o_valid, o_parity_err, o_frame_err, o_break, o_overrun, o_busy});
        end
        checks++;
        if (o_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got %h expected 00", o_data);
        end
        i_rst = 1'b1;
        drive_ticks(1'b1, 8);
    endtask

    task automatic test_basic_8n1();
        int v0;
        i_parity_en = 1'b0; i_ready = 1'b1;
        words.delete();
        v0 = vld_cycles;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, -1, 4, 1'b0);
        checks++;
        if (words.size() !== 1) begin
            errors++;
            $display("FAIL basic_count got %0d expected 1", words.size());
        end else begin
            checks++;
            if (words[0] !== {3'b000, 8'hA5}) begin
                errors++;
                $display("FAIL basic_word got %h expected %h", words[0], {3'b000, 8'hA5});
            end
        end
        checks++;
        if (vld_cycles - v0 !== 1) begin
            errors++;
            $display("FAIL basic_valid_cycles got %0d expected 1", vld_cycles - v0);
        end
    endtask

    task automatic test_parity_8e1();
        i_parity_en = 1'b1; i_parity_odd = 1'b0;
        words.delete();
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1, -1, 4, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1, -1, 4, 1'b0);
        checks++;
        if (words.size() !== 2) begin
            errors++;
            $display("FAIL parity_count got %0d expected 2", words.size());
        end else begin
            checks++;
            if (words[0] !== {3'b001, 8'h07}) begin
                errors++;
                $display("FAIL parity_bad got %h expected %h", words[0], {3'b001, 8'h07});
            end
            checks++;
            if (words[1] !== {3'b000, 8'h07}) begin
                errors++;
                $display("FAIL parity_good got %h expected %h", words[1], {3'b000, 8'h07});
            end
        end
    endtask

    task automatic test_frame_err_8n2();
        i_parity_en = 1'b0;
        words.delete();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, -1, 0, 1'b0);
        drive_ticks(1'b0, 8);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL ferr_wait_high_busy got %b expected 1", o_busy);
        end
        drive_ticks(1'b1, 4);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL ferr_idle_busy got %b expected 0", o_busy);
        end
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b1, -1, 4, 1'b0);
        checks++;
        if (words.size() !== 2) begin
            errors++;
            $display("FAIL ferr_count got %0d expected 2", words.size());
        end else begin
            checks++;
            if (words[0] !== {3'b010, 8'h3C}) begin
                errors++;
                $display("FAIL ferr_word got %h expected %h", words[0], {3'b010, 8'h3C});
            end
            checks++;
            if (words[1] !== {3'b000, 8'h55}) begin
                errors++;
                $display("FAIL ferr_next_word got %h expected %h", words[1], {3'b000, 8'h55});
            end
        end
    endtask

    task automatic test_break_8o1();
        i_parity_en = 1'b1; i_parity_odd = 1'b1;
        words.delete();
        drive_ticks(1'b0, 2 * 12 * OS);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL break_busy_low got %b expected 1", o_busy);
        end
        drive_ticks(1'b1, OS);
        checks++;
        if (words.size() !== 1) begin
            errors++;
            $display("FAIL break_count got %0d expected 1", words.size());
        end else begin
            checks++;
            // All-zero frame with odd parity: parity error as well as break + framing.
            if (words[0] !== {3'b111, 8'h00}) begin
                errors++;
                $display("FAIL break_word got %h expected %h", words[0], {3'b111, 8'h00});
            end
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL break_busy_high got %b expected 0", o_busy);
        end
    endtask

    task automatic test_overrun();
        i_parity_en = 1'b0; i_ready = 1'b0;
        words.delete();
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b1, -1, 4, 1'b0);
        checks++;
        if ({o_valid, o_overrun, o_data} !== {2'b10, 8'h11}) begin
            errors++;
            $display("FAIL ovr_first got %h expected %h", {o_valid, o_overrun, o_data}, {2'b10, 8'h11});
        end
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b1, -1, 4, 1'b0);
        checks++;
        if ({o_valid, o_overrun, o_data} !== {2'b11, 8'h11}) begin
            errors++;
            $display("FAIL ovr_held got %h expected %h", {o_valid, o_overrun, o_data}, {2'b11, 8'h11});
        end
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        checks++;
        if ({o_valid, o_overrun} !== 2'b00) begin
            errors++;
            $display("FAIL ovr_clear got %b expected 00", {o_valid, o_overrun});
        end
        words.delete();
    endtask

    task automatic test_glitch();
        i_parity_en = 1'b0; i_ready = 1'b1;
        words.delete();
        drive_ticks(1'b0, 5);
        drive_ticks(1'b1, 2 * OS);
        checks++;
        if ({words.size() != 0, o_valid, o_busy} !== 3'b000) begin
            errors++;
            $display("FAIL short_start got %b expected 000", {words.size() != 0, o_valid, o_busy});
        end
        send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 4, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 1'b1, 6, 4, 1'b0);
        checks++;
        if (words.size() !== 2) begin
            errors++;
            $display("FAIL glitch_count got %0d expected 2", words.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (words[i] !== {3'b000, 8'hF0}) begin
                    errors++;
                    $display("FAIL glitch_word%0d got %h expected %h", i, words[i], {3'b000, 8'hF0});
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        words.delete();
        drive_ticks(1'b0, OS);
        drive_ticks(1'b1, 3 * OS);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        checks++;
        if ({o_busy, o_valid} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_state got %b expected 00", {o_busy, o_valid});
        end
        i_rst = 1'b1;
        drive_ticks(1'b1, 2 * OS);
        checks++;
        if (words.size() !== 0) begin
            errors++;
            $display("FAIL midreset_words got %0d expected 0", words.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic pen, podd, pb, s0, s1, scr;
        logic [10:0] exp_w;
        i_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            d    = 8'($urandom);
            pen  = 1'($urandom);
            podd = 1'($urandom);
            pb   = (^d ^ podd) ^ ($urandom_range(0, 3) == 0);
            s0   = ($urandom_range(0, 3) != 0);
            s1   = ($urandom_range(0, 3) != 0);
            scr  = n[0];
            i_parity_en  = pen;
            i_parity_odd = podd;
            exp_w = ref_frame(d, pen, podd, pb, s0, s1);
            words.delete();
            send_frame(d, pen, pb, s0, s1, -1, 4, scr);
            checks++;
            if (words.size() !== 1) begin
                errors++;
                $display("FAIL rand%0d_count got %0d expected 1", n, words.size());
            end else begin
                checks++;
                if (words[0] !== exp_w) begin
                    errors++;
                    $display("FAIL rand%0d_word got %h expected %h", n, words[0], exp_w);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_parity_8e1();
        test_frame_err_8n2();
        test_break_8o1();
        test_overrun();
        test_glitch();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
